launch_sched: RTL and testbench
===============================

// Module: launch_sched
// PURPOSE
//  Dual-issue launch scheduler between the IF->ID instruction queue and EXE.
//  Each cycle it inspects the two queue-head instructions and launches 0, 1 or 2 of them.
//  It drives the queue's pop controls: now_allowin pops all valid heads, lunch_stall pops exactly one.
//  It also sequences serializing instructions and holds the one-cycle load-use interlock.
// PARAMETERS
//  REG_AW   5   architectural register index width
//  CNT_W    32  perf counter width (only with LAUNCH_PERF_CNT_EN)
// PORTS
//  clk              in   1        clock, rising edge
//  rst_n            in   1        reset, asynchronous, ACTIVE-HIGH (1 = reset)
//  excep_flush_i    in   1        exception flush
//  branch_flush_i   in   1        branch mispredict flush
//  line1_valid_i    in   1        queue head slot 0 valid
//  line2_valid_i    in   1        queue head slot 1 valid
//  lineN_dest_i     in   REG_AW   dest reg, N=1,2
//  lineN_we_i       in   1        dest write enable
//  lineN_src1_i     in   REG_AW   src1 reg
//  lineN_src2_i     in   REG_AW   src2 reg
//  lineN_re1_i      in   1        src1 read enable
//  lineN_re2_i      in   1        src2 read enable
//  lineN_cls_i      in   4        {serial,muldiv,mem,br} class bits
//  lineN_load_i     in   1        instruction is a load
//  exe_allowin_i    in   1        EXE accepts a launch this cycle
//  pipe_empty_i     in   1        EXE/MEM/WB hold no valid instruction
//  issue1_o         out  1        slot 0 launched this cycle
//  issue2_o         out  1        slot 1 launched this cycle
//  now_allowin_o    out  1        queue pops all valid heads
//  lunch_stall_o    out  1        queue pops exactly one head
//  perf_dual_o      out  CNT_W    dual-issue cycle count
//  perf_single_o    out  CNT_W    single-issue cycle count
//  perf_stall_o     out  CNT_W    line1 valid but no launch
// BEHAVIOUR
//  FSM state_q: NORMAL, WAIT_EMPTY, DRAIN. Reset and either flush -> NORMAL, ld_dest_q=0, ld_vld_q=0.
//  issue1 requires exe_allowin_i & line1_valid_i & !flush & !ld_use1 and:
//   NORMAL: line1 non-serial
//   WAIT_EMPTY: pipe_empty_i
//   DRAIN: never
//  NORMAL & line1 serial: issue1=0; state goes to WAIT_EMPTY next cycle.
//  WAIT_EMPTY & issue1: state goes to DRAIN.
//  DRAIN & pipe_empty_i: state goes to NORMAL. Serial instructions therefore launch alone into an empty pipe.
//  issue2 = issue1 & line2_valid_i & state==NORMAL & !line2 serial & !ld_use2 & none of:
//   RAW: line1_we & dest1!=0 & (re1&src1==dest1 | re2&src2==dest1)
//   both mem
//   both muldiv
//   line1 br
//  ld_use for line N: ld_vld_q & ld_dest_q!=0 & line N reads ld_dest_q.
//  ld_dest_q/ld_vld_q register the last launched load's dest every cycle:
//   the load's dest if a load launched
//   else ld_vld_q=0
//   if both lines launched, the slot-1 load wins
//  now_allowin_o = issue1 & !lunch_stall_o
//  lunch_stall_o = issue1 & line2_valid_i & !issue2
//  All issue/pop outputs are combinational from registered state and inputs; zero latency. During reset all are 0.
//  Flush cycle: issue1=issue2=0 (outputs low).
//  line2 valid without line1 valid: no issue2 is ever produced.
// CONFIGURATION
//  LAUNCH_PERF_CNT_EN defined: three CNT_W counters.
//   Reset/flush do not clear them; only rst_n clears them.
//   Increment rules: dual when issue2; single when issue1&!issue2; stall when line1_valid_i&!issue1.
//   Counters wrap at 2^CNT_W.
//  LAUNCH_PERF_CNT_EN undefined: no counter flops; perf_* outputs tied 0.
// STRUCTURE
//  Shared package/header: class bit positions (CLS_BR=0, CLS_MEM=1, CLS_MULDIV=2, CLS_SERIAL=3) and FSM state encodings.
//  Sub-module launch_pair_chk: purely combinational pair hazard check, returns the dual_ok bit.
// TESTING
//  T1 independent add/add, exe_allowin=1 -> issue1=issue2=1, now_allowin=1, perf_dual+1.
//  T2 line1 writes r4, line2 reads r4 -> issue2=0, lunch_stall=1; next cycle the r4 reader launches as line1.
//  T3 load r5 launched; next cycle line1 reads r5 -> issue1=0 for 1 cycle, launches the cycle after.
//  T4 serial instr, pipe busy 3 cycles -> WAIT_EMPTY 3 cycles, issue alone, DRAIN until pipe_empty, then NORMAL.
//  T5 branch_flush_i in DRAIN with ld_vld_q=1 -> next cycle state NORMAL, ld_vld_q=0, no issue during flush.
//  T6 rst_n pulsed mid-WAIT_EMPTY asynchronously -> outputs 0 immediately, state NORMAL, perf_* = 0.

Source files
------------

// File: rtl/launch_sched_pkg.sv
// ============================================================================
// Module : launch_sched_pkg
// Brief  : Shared definitions for the dual-issue launch scheduler:
//          instruction class bit positions and scheduler FSM encodings.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package launch_sched_pkg;

    // Bit positions inside the 4-bit {serial,muldiv,mem,br} class vector
    localparam int CLS_BR     = 0;
    localparam int CLS_MEM    = 1;
    localparam int CLS_MULDIV = 2;
    localparam int CLS_SERIAL = 3;
    localparam int CLS_W      = 4;

    // Scheduler states: normal dual issue, waiting for an empty pipe before a
    // serializing launch, and draining the pipe behind that launch
    typedef enum logic [1:0] {
        ST_NORMAL     = 2'd0,
        ST_WAIT_EMPTY = 2'd1,
        ST_DRAIN      = 2'd2
    } sched_state_e;

endpackage : launch_sched_pkg

`default_nettype wire

// File: rtl/launch_pair_chk.sv
// ============================================================================
// Module : launch_pair_chk
// Brief  : Combinational pairing check for the two queue-head instructions.
//          dual_ok_o is high when slot 1 may launch alongside slot 0 as far
//          as intra-pair hazards and shared resources are concerned.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module launch_pair_chk
    import launch_sched_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              line1_we_i,
    input  logic [REG_AW-1:0] line1_dest_i,
    input  logic [CLS_W-1:0]  line1_cls_i,
    input  logic [REG_AW-1:0] line2_src1_i,
    input  logic              line2_re1_i,
    input  logic [REG_AW-1:0] line2_src2_i,
    input  logic              line2_re2_i,
    input  logic [CLS_W-1:0]  line2_cls_i,
    output logic              dual_ok_o
);

    logic raw_hit;
    logic mem_conflict;
    logic muldiv_conflict;
    logic unused_line2_br;

    // A branch in slot 1 needs no special treatment; only slot 0 branches block pairing
    assign unused_line2_br = line2_cls_i[CLS_BR];

    // Slot 1 reading slot 0's result cannot be forwarded within the same launch;
    // r0 is hard-wired zero so writes to it never create a dependency
    always_comb begin
        raw_hit = 1'b0;
        if (line1_we_i && (line1_dest_i != '0)) begin
            raw_hit = (line2_re1_i && (line2_src1_i == line1_dest_i)) ||
                      (line2_re2_i && (line2_src2_i == line1_dest_i));
        end
    end

    // Single memory port and single mul/div unit in EXE
    assign mem_conflict    = line1_cls_i[CLS_MEM]    & line2_cls_i[CLS_MEM];
    assign muldiv_conflict = line1_cls_i[CLS_MULDIV] & line2_cls_i[CLS_MULDIV];

    // Serializing instructions always launch alone, and a slot 0 branch keeps
    // its delay-slot partner for the next cycle
    assign dual_ok_o = !raw_hit
                     && !mem_conflict
                     && !muldiv_conflict
                     && !line1_cls_i[CLS_BR]
                     && !line1_cls_i[CLS_SERIAL]
                     && !line2_cls_i[CLS_SERIAL];

endmodule : launch_pair_chk

`default_nettype wire

// File: rtl/launch_sched.sv
// ============================================================================
// Module : launch_sched
// Brief  : Dual-issue launch scheduler between the IF->ID instruction queue
//          and EXE. Decides per cycle whether 0, 1 or 2 queue heads launch,
//          drives the queue pop controls, sequences serializing instructions
//          through an empty pipe and holds the one-cycle load-use interlock.
//          Optional feature macro: LAUNCH_PERF_CNT_EN (performance counters).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module launch_sched
    import launch_sched_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,          // asynchronous, active-high
    input  logic              excep_flush_i,
    input  logic              branch_flush_i,
    input  logic              line1_valid_i,
    input  logic              line2_valid_i,
    input  logic [REG_AW-1:0] line1_dest_i,
    input  logic              line1_we_i,
    input  logic [REG_AW-1:0] line1_src1_i,
    input  logic [REG_AW-1:0] line1_src2_i,
    input  logic              line1_re1_i,
    input  logic              line1_re2_i,
    input  logic [CLS_W-1:0]  line1_cls_i,
    input  logic              line1_load_i,
    input  logic [REG_AW-1:0] line2_dest_i,
    input  logic              line2_we_i,
    input  logic [REG_AW-1:0] line2_src1_i,
    input  logic [REG_AW-1:0] line2_src2_i,
    input  logic              line2_re1_i,
    input  logic              line2_re2_i,
    input  logic [CLS_W-1:0]  line2_cls_i,
    input  logic              line2_load_i,
    input  logic              exe_allowin_i,
    input  logic              pipe_empty_i,
    output logic              issue1_o,
    output logic              issue2_o,
    output logic              now_allowin_o,
    output logic              lunch_stall_o,
    output logic [CNT_W-1:0]  perf_dual_o,
    output logic [CNT_W-1:0]  perf_single_o,
    output logic [CNT_W-1:0]  perf_stall_o
);

    sched_state_e      state_q;
    logic [REG_AW-1:0] ld_dest_q;
    logic [REG_AW-1:0] ld_dest_d;
    logic              ld_vld_q;
    logic              ld_vld_d;

    logic              flush;
    logic              ld_use1;
    logic              ld_use2;
    logic              state_ok1;
    logic              dual_ok;
    logic              issue1;
    logic              issue2;
    logic              unused_line2_we;

    // Slot 1's write enable does not affect any launch decision
    assign unused_line2_we = line2_we_i;

    assign flush = excep_flush_i | branch_flush_i;

    // Load-use: the load launched last cycle has no result yet for a reader now
    always_comb begin
        ld_use1 = 1'b0;
        ld_use2 = 1'b0;
        if (ld_vld_q && (ld_dest_q != '0)) begin
            ld_use1 = (line1_re1_i && (line1_src1_i == ld_dest_q)) ||
                      (line1_re2_i && (line1_src2_i == ld_dest_q));
            ld_use2 = (line2_re1_i && (line2_src1_i == ld_dest_q)) ||
                      (line2_re2_i && (line2_src2_i == ld_dest_q));
        end
    end

    // Per-state permission for slot 0: serial ops wait for an empty pipe,
    // and nothing launches while the pipe drains behind a serial op
    always_comb begin
        state_ok1 = 1'b0;
        case (state_q)
            ST_NORMAL:     state_ok1 = !line1_cls_i[CLS_SERIAL];
            ST_WAIT_EMPTY: state_ok1 = pipe_empty_i;
            ST_DRAIN:      state_ok1 = 1'b0;
            default:       state_ok1 = 1'b0;
        endcase
    end

    launch_pair_chk #(
        .REG_AW (REG_AW)
    ) u_pair_chk (
        .line1_we_i   (line1_we_i),
        .line1_dest_i (line1_dest_i),
        .line1_cls_i  (line1_cls_i),
        .line2_src1_i (line2_src1_i),
        .line2_re1_i  (line2_re1_i),
        .line2_src2_i (line2_src2_i),
        .line2_re2_i  (line2_re2_i),
        .line2_cls_i  (line2_cls_i),
        .dual_ok_o    (dual_ok)
    );

    // Reset is asynchronous, so launches are also masked combinationally while it is held
    assign issue1 = !rst_n && exe_allowin_i && line1_valid_i && !flush
                  && !ld_use1 && state_ok1;
    assign issue2 = issue1 && line2_valid_i && (state_q == ST_NORMAL)
                  && dual_ok && !ld_use2;

    assign issue1_o      = issue1;
    assign issue2_o      = issue2;
    assign lunch_stall_o = issue1 & line2_valid_i & !issue2;
    assign now_allowin_o = issue1 & !lunch_stall_o;

    // Serial-instruction sequencing FSM
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= ST_NORMAL;
        end else if (flush) begin
            state_q <= ST_NORMAL;
        end else begin
            case (state_q)
                ST_NORMAL: begin
                    if (line1_valid_i && line1_cls_i[CLS_SERIAL]) begin
                        state_q <= ST_WAIT_EMPTY;
                    end
                end
                ST_WAIT_EMPTY: begin
                    if (issue1) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pipe_empty_i) begin
                        state_q <= ST_NORMAL;
                    end
                end
                default: state_q <= ST_NORMAL;
            endcase
        end
    end

    // Track the most recently launched load; the younger slot 1 load takes priority
    always_comb begin
        ld_dest_d = ld_dest_q;
        ld_vld_d  = 1'b0;
        if (flush) begin
            ld_dest_d = '0;
        end else if (issue2 && line2_load_i) begin
            ld_dest_d = line2_dest_i;
            ld_vld_d  = 1'b1;
        end else if (issue1 && line1_load_i) begin
            ld_dest_d = line1_dest_i;
            ld_vld_d  = 1'b1;
        end
    end

    // Load-use tracking registers
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            ld_dest_q <= '0;
            ld_vld_q  <= 1'b0;
        end else begin
            ld_dest_q <= ld_dest_d;
            ld_vld_q  <= ld_vld_d;
        end
    end

`ifdef LAUNCH_PERF_CNT_EN
    logic [CNT_W-1:0] perf_dual_q;
    logic [CNT_W-1:0] perf_single_q;
    logic [CNT_W-1:0] perf_stall_q;

    // Free-running wrap-around performance counters, cleared only by reset
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            perf_dual_q   <= '0;
            perf_single_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (issue2) begin
                perf_dual_q <= perf_dual_q + 1'b1;
            end
            if (issue1 && !issue2) begin
                perf_single_q <= perf_single_q + 1'b1;
            end
            if (line1_valid_i && !issue1) begin
                perf_stall_q <= perf_stall_q + 1'b1;
            end
        end
    end

    assign perf_dual_o   = perf_dual_q;
    assign perf_single_o = perf_single_q;
    assign perf_stall_o  = perf_stall_q;
`else
    assign perf_dual_o   = '0;
    assign perf_single_o = '0;
    assign perf_stall_o  = '0;
`endif

endmodule : launch_sched

`default_nettype wire

// File: tb/tb_launch_sched.sv
// ============================================================================
// Module : tb_launch_sched
// Brief  : Directed self-checking bench for launch_sched.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_launch_sched;

`ifdef LAUNCH_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    localparam logic [3:0] C_ALU = 4'b0000;
    localparam logic [3:0] C_BR  = 4'b0001;
    localparam logic [3:0] C_MEM = 4'b0010;
    localparam logic [3:0] C_MD  = 4'b0100;
    localparam logic [3:0] C_SER = 4'b1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        excep_flush, branch_flush;
    logic        l1v, l2v;
    logic [4:0]  l1d, l1s1, l1s2, l2d, l2s1, l2s2;
    logic        l1we, l1r1, l1r2, l1ld, l2we, l2r1, l2r2, l2ld;
    logic [3:0]  l1c, l2c;
    logic        exe_allowin, pipe_empty;
    logic        issue1, issue2, now_allowin, lunch_stall;
    logic [31:0] perf_dual, perf_single, perf_stall;

    int checks = 0;
    int errors = 0;
    int m_dual = 0, m_single = 0, m_stall = 0;

    always #5 clk = ~clk;

    launch_sched #(.REG_AW(5), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .excep_flush_i(excep_flush), .branch_flush_i(branch_flush),
        .line1_valid_i(l1v), .line2_valid_i(l2v),
        .line1_dest_i(l1d), .line1_we_i(l1we), .line1_src1_i(l1s1), .line1_src2_i(l1s2),
        .line1_re1_i(l1r1), .line1_re2_i(l1r2), .line1_cls_i(l1c), .line1_load_i(l1ld),
        .line2_dest_i(l2d), .line2_we_i(l2we), .line2_src1_i(l2s1), .line2_src2_i(l2s2),
        .line2_re1_i(l2r1), .line2_re2_i(l2r2), .line2_cls_i(l2c), .line2_load_i(l2ld),
        .exe_allowin_i(exe_allowin), .pipe_empty_i(pipe_empty),
        .issue1_o(issue1), .issue2_o(issue2),
        .now_allowin_o(now_allowin), .lunch_stall_o(lunch_stall),
        .perf_dual_o(perf_dual), .perf_single_o(perf_single), .perf_stall_o(perf_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_l1(input logic v, input logic [4:0] d, input logic we,
                          input logic [4:0] s1, input logic r1, input logic [4:0] s2,
                          input logic r2, input logic [3:0] c, input logic ld);
        l1v = v; l1d = d; l1we = we; l1s1 = s1; l1r1 = r1; l1s2 = s2; l1r2 = r2; l1c = c; l1ld = ld;
    endtask

    task automatic set_l2(input logic v, input logic [4:0] d, input logic we,
                          input logic [4:0] s1, input logic r1, input logic [4:0] s2,
                          input logic r2, input logic [3:0] c, input logic ld);
        l2v = v; l2d = d; l2we = we; l2s1 = s1; l2r1 = r1; l2s2 = s2; l2r2 = r2; l2c = c; l2ld = ld;
    endtask

    task automatic chk_perf(input string tag);
        chk({tag, " perf_dual"},   perf_dual,   PERF_EN ? m_dual   : 0);
        chk({tag, " perf_single"}, perf_single, PERF_EN ? m_single : 0);
        chk({tag, " perf_stall"},  perf_stall,  PERF_EN ? m_stall  : 0);
    endtask

    // Called at posedge+1 with inputs already driven; checks at the negedge,
    // then advances the counter model and moves to the next posedge+1.
    task automatic step(input string tag, input logic e1, input logic e2);
        logic es, en;
        #4;
        es = e1 & l2v & ~e2;
        en = e1 & ~es;
        chk({tag, " issue1"},      issue1,      e1);
        chk({tag, " issue2"},      issue2,      e2);
        chk({tag, " now_allowin"}, now_allowin, en);
        chk({tag, " lunch_stall"}, lunch_stall, es);
        chk_perf(tag);
        if (e2) m_dual++;
        else if (e1) m_single++;
        if (l1v && !e1) m_stall++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        excep_flush = 1'b0; branch_flush = 1'b0;
        exe_allowin = 1'b1; pipe_empty = 1'b1;
        set_l1(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, C_ALU, 0);
        set_l2(1, 5'd6, 1, 5'd7, 1, 5'd8, 1, C_ALU, 0);

        // Reset: launchable inputs must still give all-zero outputs
        #3;
        chk("rst issue1", issue1, 0);
        chk("rst issue2", issue2, 0);
        chk("rst now_allowin", now_allowin, 0);
        chk("rst lunch_stall", lunch_stall, 0);
        chk_perf("rst");
        @(posedge clk); #1;
        rst_n = 1'b0;

        // T1 independent pair
        step("T1 dual", 1, 1);
        // T2 RAW r4
        set_l1(1, 5'd4, 1, 5'd2, 1, 5'd3, 1, C_ALU, 0);
        set_l2(1, 5'd9, 1, 5'd4, 1, 5'd1, 0, C_ALU, 0);
        step("T2 raw", 1, 0);
        set_l1(1, 5'd9, 1, 5'd4, 1, 5'd1, 0, C_ALU, 0);
        set_l2(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, C_ALU, 0);
        step("T2 reader", 1, 0);
        // T3 load-use r5
        set_l1(1, 5'd5, 1, 5'd2, 1, 5'd0, 0, C_MEM, 1);
        step("T3 load", 1, 0);
        set_l1(1, 5'd11, 1, 5'd1, 1, 5'd5, 1, C_ALU, 0);
        step("T3 ld_use", 0, 0);
        step("T3 after", 1, 0);
        // Both mem, then load-use on slot 1, then both muldiv
        set_l1(1, 5'd10, 1, 5'd2, 1, 5'd0, 0, C_MEM, 1);
        set_l2(1, 5'd0, 0, 5'd11, 1, 5'd12, 1, C_MEM, 0);
        step("both mem", 1, 0);
        set_l1(1, 5'd20, 1, 5'd1, 1, 5'd2, 1, C_ALU, 0);
        set_l2(1, 5'd21, 1, 5'd10, 1, 5'd0, 0, C_ALU, 0);
        step("ld_use2", 1, 0);
        set_l1(1, 5'd22, 1, 5'd10, 1, 5'd0, 0, C_MD, 0);
        set_l2(1, 5'd23, 1, 5'd1, 1, 5'd2, 1, C_MD, 0);
        step("both muldiv", 1, 0);
        // Slot 0 branch
        set_l1(1, 5'd0, 0, 5'd1, 1, 5'd2, 1, C_BR, 0);
        set_l2(1, 5'd24, 1, 5'd3, 1, 5'd4, 1, C_ALU, 0);
        step("line1 br", 1, 0);
        // r0 write never makes a RAW dependency
        set_l1(1, 5'd0, 1, 5'd1, 1, 5'd2, 1, C_ALU, 0);
        set_l2(1, 5'd25, 1, 5'd0, 1, 5'd0, 1, C_ALU, 0);
        step("r0 dual", 1, 1);
        // EXE back-pressure
        exe_allowin = 1'b0;
        step("no allowin", 0, 0);
        exe_allowin = 1'b1;
        // Slot 1 valid alone
        l1v = 1'b0;
        step("l2 only", 0, 0);
        // Slot 1 load wins the load tracker
        set_l1(1, 5'd26, 1, 5'd1, 1, 5'd2, 1, C_ALU, 0);
        set_l2(1, 5'd13, 1, 5'd1, 1, 5'd2, 1, C_MEM, 1);
        step("l2 load dual", 1, 1);
        set_l1(1, 5'd27, 1, 5'd13, 1, 5'd0, 0, C_ALU, 0);
        set_l2(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, C_ALU, 0);
        step("l2 ld_use", 0, 0);
        step("l2 ld after", 1, 0);

        // T4 serial with pipe busy
        set_l1(1, 5'd15, 1, 5'd1, 1, 5'd2, 1, C_SER, 0);
        set_l2(1, 5'd16, 1, 5'd3, 1, 5'd4, 1, C_ALU, 0);
        pipe_empty = 1'b0;
        step("T4 normal ser", 0, 0);
        for (int i = 0; i < 3; i++) step("T4 wait", 0, 0);
        pipe_empty = 1'b1;
        step("T4 ser launch", 1, 0);
        set_l1(1, 5'd16, 1, 5'd3, 1, 5'd4, 1, C_ALU, 0);
        set_l2(1, 5'd17, 1, 5'd5, 1, 5'd6, 1, C_ALU, 0);
        pipe_empty = 1'b0;
        step("T4 drain busy", 0, 0);
        pipe_empty = 1'b1;
        step("T4 drain empty", 0, 0);
        step("T4 normal", 1, 1);

        // T5 branch flush in DRAIN right after a serial load
        set_l1(1, 5'd14, 1, 5'd1, 1, 5'd0, 0, C_SER | C_MEM, 1);
        set_l2(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, C_ALU, 0);
        pipe_empty = 1'b0;
        step("T5 normal ser", 0, 0);
        pipe_empty = 1'b1;
        step("T5 ser load", 1, 0);
        set_l1(1, 5'd18, 1, 5'd14, 1, 5'd0, 0, C_ALU, 0);
        pipe_empty = 1'b0;
        branch_flush = 1'b1;
        step("T5 flush", 0, 0);
        branch_flush = 1'b0;
        step("T5 post flush", 1, 0);
        set_l2(1, 5'd19, 1, 5'd3, 1, 5'd4, 1, C_ALU, 0);
        excep_flush = 1'b1;
        step("excep flush", 0, 0);
        excep_flush = 1'b0;

        // T6 async reset while in WAIT_EMPTY
        set_l1(1, 5'd15, 1, 5'd1, 1, 5'd2, 1, C_SER, 0);
        set_l2(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, C_ALU, 0);
        step("T6 normal ser", 0, 0);
        step("T6 wait", 0, 0);
        pipe_empty = 1'b1;
        #2;
        chk("T6 wait launch", issue1, 1);
        rst_n = 1'b1;
        #1;
        m_dual = 0; m_single = 0; m_stall = 0;
        chk("T6 rst issue1", issue1, 0);
        chk("T6 rst now_allowin", now_allowin, 0);
        chk_perf("T6 rst");
        @(posedge clk); #1;
        rst_n = 1'b0;
        set_l1(1, 5'd16, 1, 5'd3, 1, 5'd4, 1, C_ALU, 0);
        set_l2(1, 5'd17, 1, 5'd5, 1, 5'd6, 1, C_ALU, 0);
        pipe_empty = 1'b0;
        step("T6 normal", 1, 1);
        step("T6 final", 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_launch_sched

`default_nettype wire
